// File: rtl/stream_arb_mux_pkg.sv
// Shared types and constants for the stream arbiter/mux: FSM state encoding
// and the arbitration scheme selectors.
package stream_arb_mux_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam SCHEME_RR = "RR";
   localparam SCHEME_FP = "FP";

endpackage

// File: rtl/stream_arb_pick.sv
// Combinational winner selection: fixed priority (lowest index) or round-robin
// scan starting at ptr and wrapping past PORTS-1.
module stream_arb_pick
   import stream_arb_mux_pkg::*;
#(
   parameter int PORTS  = 4,
   parameter     SCHEME = SCHEME_RR,
   localparam int PW    = $clog2(PORTS)
) (
   input  logic [PORTS-1:0] valid,
   input  logic [PW-1:0]    ptr,
   output logic [PW-1:0]    winner,
   output logic             found
);

   always_comb begin : scan
      int idx;
      idx    = 0;
      winner = '0;
      found  = 1'b0;
      for (int i = 0; i < PORTS; i++) begin
         idx = (SCHEME == SCHEME_FP) ? i : int'(ptr) + i;
         if (idx >= PORTS) idx = idx - PORTS;
         if (!found && valid[idx[PW-1:0]]) begin
            found  = 1'b1;
            winner = idx[PW-1:0];
         end
      end
   end

endmodule

// File: rtl/stream_arb_mux.sv
// Packet-granular N:1 stream arbiter with a registered output stage.
// Grant is held from the first beat until the eop beat is accepted.
//
//   state | meaning
//   IDLE  | no grant; arbitrate among valid ports (no beat accepted here)
//   BUSY  | port sel granted; forward beats until its eop is accepted
module stream_arb_mux
   import stream_arb_mux_pkg::*;
#(
   parameter int PORTS  = 4,
   parameter int DWIDTH = 8,
   parameter     SCHEME = SCHEME_RR,
   localparam int PW    = $clog2(PORTS)
) (
   input  logic                    reset,
   input  logic                    clk,
   input  logic [PORTS*DWIDTH-1:0] i_dat,
   input  logic [PORTS-1:0]        i_val,
   input  logic [PORTS-1:0]        i_eop,
   output logic [PORTS-1:0]        i_rdy,
   output logic [DWIDTH-1:0]       o_dat,
   output logic                    o_val,
   output logic                    o_eop,
   input  logic                    o_rdy,
   output logic [PW-1:0]           o_num,
   output logic                    o_busy
);

   state_t        state, state_nxt;
   logic [PW-1:0] sel, sel_nxt;
   logic [PW-1:0] ptr, ptr_nxt;
   logic [PW-1:0] winner;
   logic          found;
   logic          go;
   logic          accept;
   logic          last;

   stream_arb_pick #(
      .PORTS  (PORTS),
      .SCHEME (SCHEME)
   ) u_pick (
      .valid  (i_val),
      .ptr    (ptr),
      .winner (winner),
      .found  (found)
   );

   // Output register can take a beat when empty or draining this cycle.
   assign go     = ~o_val | o_rdy;
   assign accept = (state == BUSY) & i_val[sel] & go;
   assign last   = accept & i_eop[sel];
   assign o_busy = (state == BUSY);

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      ptr_nxt   = ptr;
      i_rdy     = '0;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = BUSY;
               sel_nxt   = winner;
               if (SCHEME == SCHEME_RR)
                  ptr_nxt = (winner == PW'(PORTS-1)) ? '0 : winner + 1'b1;
            end
         end
         BUSY: begin
            i_rdy[sel] = go;
            if (last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         sel   <= '0;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         sel   <= sel_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // Drains independently of the FSM, so IDLE with a buffered beat is normal.
   always_ff @(posedge clk) begin
      if (!reset) begin
         o_dat <= '0;
         o_eop <= 1'b0;
         o_num <= '0;
         o_val <= 1'b0;
      end else if (accept) begin
         o_dat <= i_dat[int'(sel)*DWIDTH +: DWIDTH];
         o_eop <= i_eop[sel];
         o_num <= sel;
         o_val <= 1'b1;
      end else if (o_rdy) begin
         o_val <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Scoreboard bench for stream_arb_mux: one fixed-priority and one round-robin
// instance, each fed by per-port beat queues; a monitor checks every output transfer.
module tb_stream_arb_mux;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] i_dat [2];
   logic [3:0]  i_val [2];
   logic [3:0]  i_eop [2];
   wire  [3:0]  i_rdy [2];
   wire  [7:0]  o_dat [2];
   wire         o_val [2];
   wire         o_eop [2];
   logic        o_rdy [2];
   wire  [1:0]  o_num [2];
   wire         o_busy [2];

   logic [8:0]  src_mem [2][4][64];
   int          src_wr [2][4] = '{default: 0};
   int          src_rd [2][4] = '{default: 0};
   logic [3:0]  hold [2];

   logic [10:0] exp_q0[$];
   logic [10:0] exp_q1[$];
   logic [10:0] mon_got, mon_want;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   stream_arb_mux #(.PORTS(4), .DWIDTH(8), .SCHEME("FP")) u_fp (
      .reset (rst_n), .clk (clk),
      .i_dat (i_dat[0]), .i_val (i_val[0]), .i_eop (i_eop[0]), .i_rdy (i_rdy[0]),
      .o_dat (o_dat[0]), .o_val (o_val[0]), .o_eop (o_eop[0]), .o_rdy (o_rdy[0]),
      .o_num (o_num[0]), .o_busy (o_busy[0])
   );

   stream_arb_mux #(.PORTS(4), .DWIDTH(8), .SCHEME("RR")) u_rr (
      .reset (rst_n), .clk (clk),
      .i_dat (i_dat[1]), .i_val (i_val[1]), .i_eop (i_eop[1]), .i_rdy (i_rdy[1]),
      .o_dat (o_dat[1]), .o_val (o_val[1]), .o_eop (o_eop[1]), .o_rdy (o_rdy[1]),
      .o_num (o_num[1]), .o_busy (o_busy[1])
   );

   // Source ports: present the queue head while not paused.
   always_comb begin
      for (int n = 0; n < 2; n++) begin
         i_val[n] = '0;
         i_eop[n] = '0;
         i_dat[n] = '0;
         for (int k = 0; k < 4; k++) begin
            i_val[n][k]       = (src_rd[n][k] != src_wr[n][k]) && !hold[n][k];
            i_dat[n][k*8 +: 8] = src_mem[n][k][src_rd[n][k][5:0]][7:0];
            i_eop[n][k]       = src_mem[n][k][src_rd[n][k][5:0]][8];
         end
      end
   end

   always @(posedge clk) begin
      for (int n = 0; n < 2; n++)
         for (int k = 0; k < 4; k++)
            if (i_rdy[n][k] && i_val[n][k]) src_rd[n][k] <= src_rd[n][k] + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every completed output handshake pops one expected beat.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int n = 0; n < 2; n++) begin
            if (o_val[n] && o_rdy[n]) begin
               mon_got = {o_eop[n], o_num[n], o_dat[n]};
               if ((n == 0 && exp_q0.size() == 0) || (n == 1 && exp_q1.size() == 0)) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat inst%0d: got %0h expected none", n, mon_got);
               end else begin
                  if (n == 0) mon_want = exp_q0.pop_front();
                  else        mon_want = exp_q1.pop_front();
                  check($sformatf("beat_inst%0d", n), 32'(mon_got), 32'(mon_want));
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_beat(input int n, input int k, input logic [7:0] d, input logic e);
      src_mem[n][k][src_wr[n][k]] = {e, d};
      src_wr[n][k]++;
   endtask

   task automatic expect_beat(input int n, input logic [1:0] num, input logic [7:0] d, input logic e);
      if (n == 0) exp_q0.push_back({e, num, d});
      else        exp_q1.push_back({e, num, d});
   endtask

   task automatic send(input int n, input int k, input logic [7:0] d, input logic e);
      push_beat(n, k, d, e);
      expect_beat(n, 2'(k), d, e);
   endtask

   task automatic wait_oval(input int n, input string name);
      int c = 0;
      while (!o_val[n] && c < 60) begin
         tick();
         c++;
      end
      checks++;
      if (!o_val[n]) begin
         errors++;
         $display("FAIL %s: o_val still 0 after %0d cycles, expected 1", name, c);
      end
   endtask

   task automatic wait_drain(input string name);
      int c = 0;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0 || o_val[0] || o_val[1] ||
              o_busy[0] || o_busy[1]) && c < 300) begin
         tick();
         c++;
      end
      checks++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0 || o_val[0] || o_val[1]) begin
         errors++;
         $display("FAIL %s: %0d/%0d beats outstanding after %0d cycles, expected 0",
                  name, exp_q0.size(), exp_q1.size(), c);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      o_rdy[0] = 1'b1;
      o_rdy[1] = 1'b1;
      hold[0] = '0;
      hold[1] = '0;
      repeat (3) tick();
      for (int n = 0; n < 2; n++) begin
         check($sformatf("rst_oval%0d", n), 32'(o_val[n]), 0);
         check($sformatf("rst_irdy%0d", n), 32'(i_rdy[n]), 0);
         check($sformatf("rst_busy%0d", n), 32'(o_busy[n]), 0);
         check($sformatf("rst_odat%0d", n), 32'(o_dat[n]), 0);
         check($sformatf("rst_onum%0d", n), 32'(o_num[n]), 0);
      end
      rst_n = 1'b1;
      tick();

      // Fixed priority: ports 1 and 3 valid, port 1 first.
      send(0, 1, 8'h11, 1'b0);
      send(0, 1, 8'h12, 1'b0);
      send(0, 1, 8'h13, 1'b1);
      send(0, 3, 8'h31, 1'b0);
      send(0, 3, 8'h32, 1'b1);
      check("fp_oval_bubble", 32'(o_val[0]), 0);
      tick();
      check("fp_busy", 32'(o_busy[0]), 1);
      check("fp_grant", 32'(i_rdy[0]), 32'h2);
      check("fp_bubble_oval", 32'(o_val[0]), 0);
      wait_drain("fp_drain");

      // Downstream stall of 5 cycles mid-packet.
      send(0, 0, 8'h01, 1'b0);
      send(0, 0, 8'h02, 1'b0);
      send(0, 0, 8'h03, 1'b0);
      send(0, 0, 8'h04, 1'b1);
      wait_oval(0, "stall_first");
      o_rdy[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_odat", 32'(o_dat[0]), 32'h01);
         check("stall_oval", 32'(o_val[0]), 1);
         check("stall_irdy", 32'(i_rdy[0]), 0);
      end
      o_rdy[0] = 1'b1;
      wait_drain("stall_drain");

      // Round-robin: all ports valid, 1-beat packets, order 0,1,2,3,0,1,2,3.
      for (int b = 0; b < 2; b++)
         for (int k = 0; k < 4; k++)
            send(1, k, 8'(k * 16 + b), 1'b1);
      wait_drain("rr_drain");
      check("rr_ptr_wrap", 32'(u_rr.ptr), 0);

      // Grant held while the granted port pauses; port 2 waits.
      send(1, 0, 8'h0A, 1'b0);
      send(1, 0, 8'h0B, 1'b0);
      send(1, 0, 8'h0C, 1'b1);
      send(1, 2, 8'h2A, 1'b0);
      send(1, 2, 8'h2B, 1'b1);
      wait_oval(1, "hold_first");
      hold[1][0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_busy", 32'(o_busy[1]), 1);
         check("hold_irdy", 32'(i_rdy[1]), 32'h1);
      end
      hold[1][0] = 1'b0;
      wait_drain("hold_drain");

      // Reset during a 4-beat packet; nothing from it may surface.
      push_beat(1, 1, 8'h1A, 1'b0);
      push_beat(1, 1, 8'h1B, 1'b0);
      push_beat(1, 1, 8'h1C, 1'b0);
      push_beat(1, 1, 8'h1D, 1'b1);
      wait_oval(1, "abort_first");
      rst_n = 1'b0;
      tick();
      check("abort_oval", 32'(o_val[1]), 0);
      check("abort_irdy", 32'(i_rdy[1]), 0);
      check("abort_busy", 32'(o_busy[1]), 0);
      check("abort_ptr", 32'(u_rr.ptr), 0);
      for (int k = 0; k < 4; k++) src_wr[1][k] = src_rd[1][k];
      tick();
      rst_n = 1'b1;
      tick();
      // Ports 1 and 3 valid: from ptr 0 port 1 must win first.
      send(1, 1, 8'h1E, 1'b1);
      send(1, 3, 8'h3E, 1'b1);
      wait_drain("post_rst_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stream_arb_mux.md
STREAM_ARB_MUX -- requirements
Module: stream_arb_mux

Interface
REQ-001 Parameter PORTS, default 4, number of input streams (PORTS > 1).
REQ-002 Parameter DWIDTH, default 8, data beat width in bits.
REQ-003 Parameter SCHEME, default "RR", arbitration scheme: "RR" round-robin, "FP" fixed priority (port 0 highest).
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 i_dat  input  PORTS*DWIDTH  input data; port k occupies bits [k*DWIDTH +: DWIDTH].
REQ-007 i_val  input  PORTS  per-port beat valid.
REQ-008 i_eop  input  PORTS  per-port end-of-packet marker, qualified by i_val.
REQ-009 i_rdy  output  PORTS  per-port ready; at most one bit set.
REQ-010 o_dat  output  DWIDTH  registered output data.
REQ-011 o_val  output  1  registered output valid.
REQ-012 o_eop  output  1  registered output end-of-packet.
REQ-013 o_rdy  input  1  downstream ready.
REQ-014 o_num  output  $clog2(PORTS)  source port index of the beat in the output register.
REQ-015 o_busy  output  1  high while the FSM is in BUSY.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and BUSY.
REQ-017 In IDLE with |i_val = 1, the block SHALL latch the arbitration winner into sel and enter BUSY next cycle; no input beat is accepted in IDLE (1-cycle arbitration bubble).
REQ-018 Winner: "FP" picks the lowest-index valid port; "RR" picks the first valid port at or above pointer ptr, wrapping from PORTS-1 to 0.
REQ-019 In "RR", ptr SHALL load (winner+1) mod PORTS on each IDLE->BUSY transition; it is unchanged otherwise.
REQ-020 In BUSY, i_rdy[sel] = ~o_val | o_rdy; all other i_rdy bits are 0; in IDLE, i_rdy = 0.
REQ-021 A beat is accepted when i_val[sel] & i_rdy[sel]; on that edge o_dat, o_eop load the port data, o_num loads sel, and o_val is set.
REQ-022 An accepted beat with i_eop[sel] = 1 SHALL return the FSM to IDLE on the same edge.
REQ-023 Grant SHALL be held until the eop beat is accepted, even if i_val[sel] drops mid-packet; other ports' valids are ignored during that time.
REQ-024 With o_val & o_rdy and no accept on the same edge, o_val SHALL clear; with accept and o_rdy together, the register reloads (full throughput, 1 beat/cycle in BUSY).
REQ-025 With o_val & ~o_rdy, o_dat, o_eop, o_num and o_val SHALL hold.
REQ-026 Latency: accepted beat appears on o_dat one cycle after acceptance.
REQ-027 The output register SHALL drain independently of FSM state; IDLE with o_val = 1 is legal.
REQ-028 Single-beat packet (eop on first beat): BUSY lasts exactly one accept cycle.

Reset
REQ-029 While reset = 0 at a rising edge: state = IDLE, ptr = 0, sel = 0, o_val = 0, o_eop = 0, o_dat = 0, o_num = 0; hence i_rdy = 0 and o_busy = 0.
REQ-030 Reset mid-packet SHALL abort the packet and discard any output-register beat; no partial state survives.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (IDLE, BUSY) and the scheme string constants "RR"/"FP".
REQ-032 Winner selection SHALL be a combinational sub-module stream_arb_pick (inputs: valid vector, ptr, SCHEME; output: winner index and found flag); the FSM, pointer and output register stay in stream_arb_mux.

Verification (PORTS=4, DWIDTH=8)
REQ-033 FP, i_val=4'b1010 in IDLE -> port 1 wins; 3-beat packet 0x11,0x12,0x13(eop) appears on o_dat in order with o_num=1; port 3 is served afterwards.
REQ-034 RR, all ports continuously valid with 1-beat packets -> grant order 0,1,2,3,0; ptr wraps 3->0.
REQ-035 o_rdy held 0 for 5 cycles mid-packet -> o_dat holds, i_rdy[sel] = 0 after the first buffered beat, no beat lost or duplicated.
REQ-036 i_val[sel] drops 3 cycles mid-packet while port 2 is valid -> port 2 is not granted until the eop of the current packet is accepted.
REQ-037 reset = 0 asserted during beat 2 of 4 -> next edge o_val=0, i_rdy=0, o_busy=0, ptr=0; the first post-reset grant follows REQ-018 from ptr=0.
